// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_arbiter
//  Description : Shares one external combinational single-precision fp_add
//                between two requesters. Round-robin grant, registered
//                operands into the adder, and a registered, tagged response
//                channel. Subtract is done by flipping the sign of b. Exact
//                zeros bypass the adder, because the adder assumes normalised
//                operands. One operation is in flight at a time.
//
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                reqN_valid/ready      - request handshake, requester N (0/1)
//                reqN_a/b/sub          - operands and subtract select
//                add_a, add_b          - registered operands to fp_add
//                add_result            - fp_add result (combinational)
//                rsp_valid/ready       - response handshake
//                rsp_id, rsp_result    - requester tag and registered result
//                busy                  - operation in flight (EXEC or RESP)
//                ops_done              - completed response handshakes (wraps)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_sub,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_last_grant;
    logic        r_id;

    logic        w_any_valid;
    logic        w_grant_id;
    logic        w_accept;
    logic        w_a_zero;
    logic        w_b_zero;
    logic [31:0] w_result;
    logic [31:0] w_grant_a;
    logic [31:0] w_grant_b;
    logic        w_grant_sub;

    // Round-robin: on contention the requester that was not served last wins.
    // With a single valid requester the grant simply follows req1_valid.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = (r_state == c_IDLE) & w_any_valid;

    assign w_grant_a   = w_grant_id ? req1_a   : req0_a;
    assign w_grant_b   = w_grant_id ? req1_b   : req0_b;
    assign w_grant_sub = w_grant_id ? req1_sub : req0_sub;

    // Signed zeros are zeros too; only the magnitude field is inspected.
    assign w_a_zero = (add_a[30:0] == 31'd0);
    assign w_b_zero = (add_b[30:0] == 31'd0);

    always_comb begin
        w_result = add_result;
        if (w_a_zero && w_b_zero) begin
            w_result = 32'h0000_0000;
        end else if (w_a_zero) begin
            w_result = add_b;
        end else if (w_b_zero) begin
            w_result = add_a;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_any_valid) w_next_state = c_EXEC;
            c_EXEC:  w_next_state = c_RESP;
            c_RESP:  if (rsp_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready = w_accept & ~w_grant_id;
        req1_ready = w_accept &  w_grant_id;
        busy       = (r_state != c_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            add_a        <= 32'd0;
            add_b        <= 32'd0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 32'd0;
            ops_done     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        add_a        <= w_grant_a;
                        add_b        <= {w_grant_b[31] ^ w_grant_sub, w_grant_b[30:0]};
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                    end
                end
                c_EXEC: begin
                    rsp_result <= w_result;
                    rsp_id     <= r_id;
                    rsp_valid  <= 1'b1;
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_arbiter
//  Description : Self-checking bench for fp_add_arbiter. A small lookup table
//                stands in for the combinational fp_add for the operand pairs
//                used here; any other pair yields a poison value, so results
//                that must come from the zero bypass cannot come from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready, req0_sub;
    logic [31:0]      req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_sub;
    logic [31:0]      req1_a, req1_b;
    logic [31:0]      add_a, add_b, add_result;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [31:0]      rsp_result;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ops  = 0;
    logic [32:0] exp_q[$];

    fp_add_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    // Stand-in adder for the operand pairs exercised below.
    always_comb begin
        case ({add_a, add_b})
            {32'h3F80_0000, 32'h4000_0000}: add_result = 32'h4040_0000; // 1+2
            {32'h4040_0000, 32'hBF80_0000}: add_result = 32'h4000_0000; // 3-1
            {32'h3F80_0000, 32'h3F80_0000}: add_result = 32'h4000_0000; // 1+1
            {32'h4000_0000, 32'h4000_0000}: add_result = 32'h4080_0000; // 2+2
            default:                        add_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input logic id);
        return id ? req1_ready : req0_ready;
    endfunction

    // Response monitor: every response handshake is checked against the queue.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id=%0d result=%08h expected none", rsp_id, rsp_result);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
                chk("rsp_result", rsp_result, e[31:0]);
            end
        end
    end

    // Single-requester operation with latency and operand checks.
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] exp_b, input logic [31:0] exp_r);
        int waited;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
        @(negedge clk);
        waited = 0;
        while (!rdy(id) && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_granted", {31'd0, rdy(id)}, 32'd1);
        chk("req_ready_other", {31'd0, rdy(!id)}, 32'd0);
        exp_q.push_back({id, exp_r});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("add_a", add_a, a);
        chk("add_b", add_b, exp_b);
        chk("busy_exec", {31'd0, busy}, 32'd1);
        chk("rsp_valid_exec", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rsp_valid_latency", {31'd0, rsp_valid}, 32'd1);
        exp_ops++;
        @(negedge clk);
        chk("ops_done", 32'(ops_done), 32'(exp_ops));
    endtask

    task automatic wait_ops(input int target);
        int cyc;
        cyc = 0;
        while (32'(ops_done) != 32'(target) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ops_done_wait", 32'(ops_done), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n1, ng, cyc;
        logic [3:0] ord;

        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ops_done", 32'(ops_done), 32'd0);
        chk("reset_add_a", add_a, 32'd0);
        chk("reset_add_b", add_b, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1.0 + 2.0, then 3.0 - 1.0
        do_op(1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000);
        do_op(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h4000_0000);

        // Both requesters continuously valid from reset
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h4000_0000; req1_b = 32'h4000_0000; req1_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ops = 0;
        n0 = 0; n1 = 0; ng = 0; cyc = 0; ord = 4'b0000;
        while (ng < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (req0_ready) begin
                n0++; ord[ng[1:0]] = 1'b0; ng++;
                exp_q.push_back({1'b0, 32'h4000_0000});
            end
            if (req1_ready) begin
                n1++; ord[ng[1:0]] = 1'b1; ng++;
                exp_q.push_back({1'b1, 32'h4080_0000});
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc = 0;
        while (32'(ops_done) != 32'd4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (req0_ready) n0++;
            if (req1_ready) n1++;
        end
        chk("rr_grant_order", {28'd0, ord}, 32'h0000_000A);
        chk("rr_req0_ready_count", 32'(n0), 32'd2);
        chk("rr_req1_ready_count", 32'(n1), 32'd2);
        chk("rr_ops_done", 32'(ops_done), 32'd4);
        exp_ops = 4;

        // Back-pressure with both requesters waiting
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("stall_grant0", {31'd0, req0_ready}, 32'd1);
        chk("stall_nogrant1", {31'd0, req1_ready}, 32'd0);
        exp_q.push_back({1'b0, 32'h4000_0000});
        @(posedge clk);
        @(negedge clk);
        chk("stall_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_result", rsp_result, 32'h4000_0000);
            chk("stall_rsp_id", {31'd0, rsp_id}, 32'd0);
            chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("stall_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("handshake_cycle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("post_stall_grant1", {31'd0, req1_ready}, 32'd1);
        chk("post_stall_nogrant0", {31'd0, req0_ready}, 32'd0);
        exp_q.push_back({1'b1, 32'h4080_0000});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_ops = 6;
        wait_ops(exp_ops);

        // Zero bypass: 0 - 1.5, -0 + 0, 1.0 + -0
        do_op(1'b0, 32'h0000_0000, 32'h3FC0_0000, 1'b1, 32'hBFC0_0000, 32'hBFC0_0000);
        do_op(1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000);
        do_op(1'b0, 32'h3F80_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h3F80_0000);

        // Reset during EXEC drops the operation
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_sub = 1'b0;
        @(negedge clk);
        chk("pre_reset_grant", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("exec_busy_before_reset", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midop_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midop_reset_busy", {31'd0, busy}, 32'd0);
        chk("midop_reset_ops_done", 32'(ops_done), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_a = 32'h4000_0000; req1_b = 32'h4000_0000; req1_sub = 1'b0;
        @(negedge clk);
        chk("after_reset_grant0", {31'd0, req0_ready}, 32'd1);
        chk("after_reset_nogrant1", {31'd0, req1_ready}, 32'd0);
        exp_q.push_back({1'b0, 32'h4040_0000});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_ops(1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
